// File: rtl/pcie_phy_pkg.sv
// Shared constants for the PCIe physical-layer lane datapath.
//
// Contents:
//   PAD_BYTE   - K23.7 PAD symbol used to fill unused active lanes
//   W_X1/X2/X4 - link_width encodings (2'b11 is treated as x4 by users)
//   NUM_LANES  - physical lane count of the datapath
package pcie_phy_pkg;

    localparam logic [7:0] PAD_BYTE  = 8'hF7;

    localparam logic [1:0] W_X1      = 2'b00;
    localparam logic [1:0] W_X2      = 2'b01;
    localparam logic [1:0] W_X4      = 2'b10;

    localparam int         NUM_LANES = 4;

endpackage : pcie_phy_pkg

// File: rtl/lane_byte_striper.sv
// lane_byte_striper
//
// Stripes a serial byte stream across 1, 2 or 4 active lanes (lane 0 first)
// and presents one registered lane group per completed stripe. A flush
// closes a partial group, padding the remaining active lanes with PAD_BYTE.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-low reset
//   in_data    - incoming byte
//   in_valid   - in_data valid this cycle (always accepted, no backpressure)
//   flush      - close the current partial group this cycle
//   link_width - 00 = x1, 01 = x2, 10/11 = x4; sampled at the start of a group
//   out0..out3 - registered lane bytes, held between groups
//   out_valid  - one-cycle pulse marking a new lane group
//   out_strb   - bit i set when lane i carries a real (non-pad) byte
module lane_byte_striper #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] PAD_BYTE = pcie_phy_pkg::PAD_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [1:0]        link_width,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic              out_valid,
    output logic [3:0]        out_strb
);

    import pcie_phy_pkg::*;

    // Active lane count for a link_width encoding; 2'b11 behaves as x4.
    function automatic logic [2:0] lane_count(input logic [1:0] w);
        logic [2:0] n;
        case (w)
            W_X1:    n = 3'd1;
            W_X2:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        cnt_reg;
    logic [1:0]        cnt_next;
    logic [1:0]        width_reg;
    logic [1:0]        width_next;
    logic [DATA_W-1:0] hold_reg [NUM_LANES];
    logic [DATA_W-1:0] lane_reg [NUM_LANES];
    logic [DATA_W-1:0] lane_next [NUM_LANES];
    logic [3:0]        strb_reg;
    logic [3:0]        strb_next;
    logic              valid_reg;

    // ------------------------------------------------------------------
    // Group control
    // ------------------------------------------------------------------
    logic [2:0] n_active;   // lanes in use for the group being built
    logic [2:0] fill;       // real bytes in the group if it closes now
    logic       complete;
    logic       emit;

    always_comb begin
        // The first byte of a group latches the width; the same cycle must
        // already use it so that x1 completes on its first byte.
        width_next = width_reg;
        if (cnt_reg == 2'd0 && in_valid) begin
            width_next = link_width;
        end

        n_active = lane_count(width_next);
        fill     = {1'b0, cnt_reg} + {2'b00, in_valid};
        complete = in_valid && ({1'b0, cnt_reg} == (n_active - 3'd1));
        // A flush with nothing held and no byte arriving is a no-op.
        emit     = complete || (flush && (cnt_reg != 2'd0 || in_valid));

        cnt_next = cnt_reg;
        if (emit) begin
            cnt_next = 2'd0;
        end else if (in_valid) begin
            cnt_next = cnt_reg + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane output selection
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] cur_byte;
            logic              is_real;
            logic              is_pad;

            // The byte arriving this cycle has not reached hold_reg yet.
            assign cur_byte = (in_valid && cnt_reg == 2'(gi)) ? in_data
                                                              : hold_reg[gi];
            assign is_real  = fill > 3'(gi);
            assign is_pad   = !is_real && (n_active > 3'(gi));

            assign lane_next[gi] = !emit   ? lane_reg[gi] :
                                   is_real ? cur_byte     :
                                   is_pad  ? PAD_BYTE     :
                                             '0;
            assign strb_next[gi] = emit ? is_real : strb_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= 2'd0;
            width_reg <= W_X4;
            strb_reg  <= 4'b0000;
            valid_reg <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                hold_reg[i] <= '0;
                lane_reg[i] <= '0;
            end
        end else begin
            cnt_reg   <= cnt_next;
            width_reg <= width_next;
            strb_reg  <= strb_next;
            valid_reg <= emit;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (in_valid && cnt_reg == 2'(i)) begin
                    hold_reg[i] <= in_data;
                end
                lane_reg[i] <= lane_next[i];
            end
        end
    end

    assign out0      = lane_reg[0];
    assign out1      = lane_reg[1];
    assign out2      = lane_reg[2];
    assign out3      = lane_reg[3];
    assign out_valid = valid_reg;
    assign out_strb  = strb_reg;

endmodule : lane_byte_striper

// File: tb/tb_lane_byte_striper.sv
// Self-checking bench for lane_byte_striper: directed vector table,
// hand-written reset sequences and a randomized run against a queue-based
// reference model.
module tb_lane_byte_striper;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       flush;
    logic [1:0] link_width;
    logic [7:0] out0, out1, out2, out3;
    logic       out_valid;
    logic [3:0] out_strb;

    int checks   = 0;
    int failures = 0;

    lane_byte_striper dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .flush      (flush),
        .link_width (link_width),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out_valid  (out_valid),
        .out_strb   (out_strb)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] lanes();
        return {out0, out1, out2, out3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic [1:0] lw);
        in_valid   = v;
        in_data    = d;
        flush      = f;
        link_width = lw;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic ev, input logic [3:0] es,
                             input logic [31:0] el);
        check({name, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({name, "_strb"},  {28'd0, out_strb},  {28'd0, es});
        check({name, "_lanes"}, lanes(), el);
    endtask

    // ------------------------------------------------------------------
    // Reference model: bytes collect in a queue; a group closes when the
    // queue reaches the width chosen by its first byte, or on flush.
    // ------------------------------------------------------------------
    logic [7:0]  mq[$];
    int          m_n;
    logic        m_valid;
    logic [3:0]  m_strb;
    logic [31:0] m_lanes;

    function automatic int width_to_n(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_n     = 4;
        m_valid = 1'b0;
        m_strb  = 4'b0000;
        m_lanes = 32'h0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic f, input logic [1:0] lw);
        m_valid = 1'b0;
        if (mq.size() == 0 && v) m_n = width_to_n(lw);
        if (v) mq.push_back(d);
        if (mq.size() == m_n || (f && mq.size() > 0)) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] b;
                if (i < mq.size()) b = mq[i];
                else if (i < m_n)  b = 8'hF7;
                else               b = 8'h00;
                m_lanes[31 - 8*i -: 8] = b;
                m_strb[i] = (i < mq.size());
            end
            m_valid = 1'b1;
            mq.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic [1:0]  lw;
        logic        ev;
        logic [3:0]  es;
        logic [31:0] el;   // {out0, out1, out2, out3}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [7:0] d, input logic f, input logic [1:0] lw,
                       input logic ev, input logic [3:0] es, input logic [31:0] el);
        vec_t r;
        r.v = v; r.d = d; r.f = f; r.lw = lw; r.ev = ev; r.es = es; r.el = el;
        tbl.push_back(r);
    endtask

    initial begin
        int nvec;
        logic [7:0] rd;

        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 2'b10);

        // ---- reset held low while a stream is driven ----
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 2'b10);
            step();
            check_all("rst_hold", 1'b0, 4'h0, 32'h0);
            $display("reset-hold cycle %0d out_valid=%0d", i, out_valid);
        end

        // ---- release mid-stream: first group starts at the next byte ----
        drive(1'b1, 8'h31, 1'b0, 2'b10);
        #3 reset = 1'b1;
        step();
        check_all("rel_b0", 1'b0, 4'h0, 32'h0);
        drive(1'b1, 8'h32, 1'b0, 2'b10); step();
        check_all("rel_b1", 1'b0, 4'h0, 32'h0);
        drive(1'b1, 8'h33, 1'b0, 2'b10); step();
        check_all("rel_b2", 1'b0, 4'h0, 32'h0);
        drive(1'b1, 8'h34, 1'b0, 2'b10); step();
        check_all("rel_grp", 1'b1, 4'hF, 32'h31323334);
        $display("release-mid-stream group lanes=%h strb=%b", lanes(), out_strb);
        drive(1'b0, 8'h00, 1'b0, 2'b10); step();
        check_all("rel_pulse", 1'b0, 4'hF, 32'h31323334);

        // ---- directed table ----
        // x4 back-to-back
        add(1, 8'h11, 0, 2'b10, 0, 4'hF, 32'h31323334);
        add(1, 8'h22, 0, 2'b10, 0, 4'hF, 32'h31323334);
        add(1, 8'h33, 0, 2'b10, 0, 4'hF, 32'h31323334);
        add(1, 8'h44, 0, 2'b10, 1, 4'hF, 32'h11223344);
        add(0, 8'h00, 0, 2'b10, 0, 4'hF, 32'h11223344);
        // x4 with bubbles
        add(1, 8'hAA, 0, 2'b10, 0, 4'hF, 32'h11223344);
        add(0, 8'h00, 0, 2'b10, 0, 4'hF, 32'h11223344);
        add(1, 8'hBB, 0, 2'b10, 0, 4'hF, 32'h11223344);
        add(0, 8'h00, 0, 2'b10, 0, 4'hF, 32'h11223344);
        add(1, 8'hCC, 0, 2'b10, 0, 4'hF, 32'h11223344);
        add(0, 8'h00, 0, 2'b10, 0, 4'hF, 32'h11223344);
        add(1, 8'hDD, 0, 2'b10, 1, 4'hF, 32'hAABBCCDD);
        // x2
        add(1, 8'hA1, 0, 2'b01, 0, 4'hF, 32'hAABBCCDD);
        add(1, 8'hB2, 0, 2'b01, 1, 4'h3, 32'hA1B20000);
        add(1, 8'hC3, 0, 2'b01, 0, 4'h3, 32'hA1B20000);
        add(1, 8'hD4, 0, 2'b01, 1, 4'h3, 32'hC3D40000);
        // flush with a valid byte, then flush alone at cnt 0
        add(1, 8'h55, 0, 2'b10, 0, 4'h3, 32'hC3D40000);
        add(1, 8'h66, 0, 2'b10, 0, 4'h3, 32'hC3D40000);
        add(1, 8'h77, 1, 2'b10, 1, 4'h7, 32'h556677F7);
        add(0, 8'h00, 1, 2'b10, 0, 4'h7, 32'h556677F7);
        // width change mid-group takes effect at the next group
        add(1, 8'h01, 0, 2'b10, 0, 4'h7, 32'h556677F7);
        add(1, 8'h02, 0, 2'b10, 0, 4'h7, 32'h556677F7);
        add(0, 8'h00, 0, 2'b00, 0, 4'h7, 32'h556677F7);
        add(1, 8'h03, 0, 2'b00, 0, 4'h7, 32'h556677F7);
        add(1, 8'h04, 0, 2'b00, 1, 4'hF, 32'h01020304);
        add(1, 8'h05, 0, 2'b00, 1, 4'h1, 32'h05000000);
        // flush on the completing byte: no extra pad group
        add(1, 8'hE1, 0, 2'b01, 0, 4'h1, 32'h05000000);
        add(1, 8'hE2, 1, 2'b01, 1, 4'h3, 32'hE1E20000);
        add(0, 8'h00, 1, 2'b01, 0, 4'h3, 32'hE1E20000);
        // single-byte flush at x4, and held-byte flush at x2
        add(1, 8'h99, 1, 2'b10, 1, 4'h1, 32'h99F7F7F7);
        add(1, 8'hAB, 0, 2'b01, 0, 4'h1, 32'h99F7F7F7);
        add(0, 8'h00, 1, 2'b01, 1, 4'h1, 32'hABF70000);

        nvec = tbl.size();
        for (int i = 0; i < nvec; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].lw);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].el);
            $display("vec %0d v=%0d d=%h f=%0d lw=%b -> valid=%0d strb=%b lanes=%h",
                     i, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].lw, out_valid, out_strb, lanes());
        end

        // ---- async reset pulse mid-group ----
        drive(1'b1, 8'h09, 1'b0, 2'b10); step();
        drive(1'b1, 8'h0A, 1'b0, 2'b10); step();
        drive(1'b0, 8'h00, 1'b0, 2'b10);
        #2 reset = 1'b0;
        #1;
        check_all("arst_clear", 1'b0, 4'h0, 32'h0);
        #1 reset = 1'b1;
        step();
        check_all("arst_nogrp", 1'b0, 4'h0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 1'b0, 2'b10);
            step();
        end
        check_all("arst_grp", 1'b1, 4'hF, 32'h01020304);
        $display("post-reset group lanes=%h strb=%b", lanes(), out_strb);

        // ---- randomized run against the model ----
        drive(1'b0, 8'h00, 1'b0, 2'b10);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic v, f;
            logic [1:0] lw;
            v  = ($urandom_range(0, 9) < 7);
            f  = ($urandom_range(0, 9) == 0);
            lw = 2'($urandom);
            rd = 8'($urandom);
            drive(v, rd, f, lw);
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b0;
                #1;
                check_all("rnd_arst", 1'b0, 4'h0, 32'h0);
                reset = 1'b1;
                model_reset();
                $display("random cycle %0d async reset pulse", c);
            end
            step();
            model_step(v, rd, f, lw);
            check_all("rnd", m_valid, m_strb, m_lanes);
            if (m_valid)
                $display("random cycle %0d group lanes=%h strb=%b", c, m_lanes, m_strb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lane_byte_striper

// File: doc/lane_byte_striper.md
Name: lane_byte_striper

Overview:
- Upstream neighbour of the 4-lane registered output stage in the PCIe physical layer.
- Takes a serial byte stream (8 bits plus valid) and stripes consecutive bytes across the active lanes: lane 0 first, then 1, 2, 3.
- Presents one registered lane group per completed stripe, with a valid pulse and per-lane strobe.
- Supports x1/x2/x4 link widths, plus a flush that closes a partial group using PAD symbols.

Parameters:
- DATA_W, 8, width of each byte and lane (fixed at 8; kept for readability only).
- PAD_BYTE, 8'hF7, filler byte for unused active lanes on flush (K23.7 PAD).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle; there is no backpressure, and every valid byte is accepted.
- flush  input  1  close the current partial group this cycle.
- link_width  input  2  active lane count: 00 = x1, 01 = x2, 10 = x4, 11 = x4.
- out0, out1, out2, out3  output  8 each  lane bytes, registered.
- out_valid  output  1  one-cycle pulse; the lane group is new this cycle.
- out_strb  output  4  bit i = 1 means lane i carries a real byte; 0 means pad or inactive.

Behaviour:
- Reset (reset = 0, asynchronous):
  - out0..out3 = 0, out_valid = 0, out_strb = 0.
  - Byte counter cnt = 0, holding registers = 0, width_q = x4.
  - A reset mid-group discards any partial bytes; nothing is emitted for them.
- Active lane count N comes from width_q: 1, 2 or 4.
- Width latching:
  - width_q is loaded from link_width only on a cycle where cnt == 0 and in_valid = 1, i.e. at the start of a group.
  - Changes to link_width mid-group take effect at the next group.
- Counter and state:
  - cnt ranges 0..N-1. cnt == 0 is the IDLE state; cnt > 0 is the COLLECT state.
  - When in_valid = 1, in_data is written to hold[cnt].
- Group completion (normal):
  - Trigger: in_valid = 1 and cnt == N-1 (the N used is the width just latched when cnt == 0).
  - On the next edge: out_i = byte for lanes i < N, 0 for lanes i >= N; out_strb has the low N bits set; out_valid = 1; cnt returns to 0.
  - Latency is 1 cycle from the last byte's accepting edge to out_valid.
  - x1 case: every valid byte emits on the following cycle on out0 with strb 0001.
- Flush:
  - Flush with cnt > 0 or in_valid = 1 emits on the next edge. The group contains the held bytes plus the current byte if it is valid.
  - Remaining active lanes (< N) are filled with PAD_BYTE and their strobe bits are 0. Inactive lanes are 0.
  - Afterwards cnt = 0.
  - Flush with cnt == 0 and in_valid = 0: no emission, no state change.
  - Flush while the current byte completes the group: identical to normal completion, with no extra pad group.
- Bubbles: in_valid = 0 without flush holds cnt and the held bytes indefinitely.
- Output hold:
  - When out_valid = 0, out0..out3 and out_strb keep their last emitted values.
  - out_valid is a single-cycle pulse; back-to-back groups give consecutive pulses.
- Throughput: one byte per cycle, so at x4 there is at most one group every 4 cycles.

Decomposition:
- Shared package pcie_phy_pkg holds:
  - PAD_BYTE (8'hF7)
  - link width encodings (W_X1 = 2'b00, W_X2 = 2'b01, W_X4 = 2'b10)
  - lane count constant NUM_LANES = 4
- No sub-module is required; the width decode (link_width to N) stays as an internal function.

Test Plan:
- Reset: hold reset = 0 while driving in_valid = 1 with random data -> out0..out3 = 00, out_valid = 0, out_strb = 0000. Releasing reset mid-stream -> first group starts from the next valid byte.
- x4 stream: 11, 22, 33, 44 on consecutive cycles -> one cycle after 44, out0..out3 = 11, 22, 33, 44, strb 1111, out_valid for exactly 1 cycle. Repeat with idle bubbles between bytes -> same single group.
- x2: A1, B2, C3, D4 -> first group A1, B2, 00, 00 with strb 0011; second group C3, D4, 00, 00 with strb 0011.
- Flush: x4 bytes 55, 66, then flush = 1 with in_valid = 1 carrying 77 -> 55, 66, 77, F7 with strb 0111. Flush alone afterwards with cnt = 0 -> no out_valid.
- Width change mid-group: x4 bytes 01, 02, then link_width = x1, then bytes 03, 04 -> group 01, 02, 03, 04 with strb 1111. Next byte 05 -> out0 = 05, strb 0001, one cycle later.
- Async reset mid-group: x4 bytes 09, 0A, then pulse reset low between clock edges -> outputs clear immediately and no group is emitted. Subsequent 1, 2, 3, 4 -> group 01, 02, 03, 04.
